// File: rtl/mem_io_responder.sv
// mem_io_responder: data-bus responder for the processor. Decodes addr[15:12]
// into a word RAM, an LED register, a one-shot down-counting timer and a
// synchronized switch port. Every read returns registered data one cycle after
// the address is presented. The processor relies on this latency for fetches
// and loads.
module mem_io_responder #(
    parameter int RAM_AW = 8,   // RAM word-address width
    parameter int SW_W   = 10,  // switch input width
    parameter int LED_W  = 10   // LED register width
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      addr,
    input  logic [15:0]      dout,
    input  logic             w,
    output logic [15:0]      din,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] ledr
);

    // Region codes taken from addr[15:12]. Codes 0x4..0xF are unmapped.
    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_TMR = 4'h2;
    localparam logic [3:0] REG_SW  = 4'h3;

    localparam int RAM_DEPTH = 1 << RAM_AW;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [3:0]        region;
    logic [RAM_AW-1:0] ram_idx;
    logic              sel_ram;
    logic              sel_led;
    logic              sel_tmr;
    logic              sel_sw;

    assign region  = addr[15:12];
    assign ram_idx = addr[RAM_AW-1:0];
    assign sel_ram = (region == REG_RAM);
    assign sel_led = (region == REG_LED);
    assign sel_tmr = (region == REG_TMR);
    assign sel_sw  = (region == REG_SW);

    // The RAM index uses the low bits and the timer uses only addr[0]. The
    // bits between them alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[11:RAM_AW];

    // Write strobes. Each one targets exactly one region.
    logic ram_we;
    logic led_we;
    logic tmr_load;
    logic tmr_clr;

    assign ram_we   = w && sel_ram;
    assign led_we   = w && sel_led;
    assign tmr_load = w && sel_tmr && !addr[0];
    assign tmr_clr  = w && sel_tmr &&  addr[0] && dout[0];

    // ------------------------------------------------------------------
    // Word RAM
    // ------------------------------------------------------------------
    logic [15:0] mem_q [RAM_DEPTH];
    logic [15:0] ram_rdata_q;

    // RAM write port and registered read port. The read samples the word
    // before this edge's write, so the read-first behavior comes for free.
    // NOTE: the array and its read register have no reset. Reset fans out to
    // every word and prevents block-RAM mapping. Software must not rely on
    // the power-up contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= dout;
        end
        ram_rdata_q <= mem_q[ram_idx];
    end

    // ------------------------------------------------------------------
    // LED, timer and switch state: next-state logic
    // ------------------------------------------------------------------
    logic [LED_W-1:0] led_q,   led_d;
    logic [15:0]      cnt_q,   cnt_d;
    logic             run_q,   run_d;
    logic             exp_q,   exp_d;
    logic [SW_W-1:0]  sync1_q, sync2_q;

    // Next state for the LED register and the timer. The order of the
    // assignments sets priority. A clear runs before the expiry, so an
    // expiry in the same cycle still sets exp. A load overrides the
    // decrement and the expiry, so a reload on the terminal cycle does not
    // set exp.
    // NOTE: every combinational output gets a default first. A path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        led_d = led_q;
        cnt_d = cnt_q;
        run_d = run_q;
        exp_d = exp_q;

        if (led_we) begin
            led_d = dout[LED_W-1:0];
        end

        if (tmr_clr) begin
            exp_d = 1'b0;
        end

        if (tmr_load) begin
            cnt_d = dout;
            run_d = (dout != 16'd0);
        end else if (run_q) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                run_d = 1'b0;
                exp_d = 1'b1;
            end
        end
    end

    // Register the LED, the timer and the two-flop switch synchronizer.
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from the values present before the
    // clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            exp_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    assign ledr = led_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // The RAM data is registered inside the RAM block, so the final mux sits
    // after the registers. A reset value for the RAM-select flag that points
    // away from the RAM makes din read zero during reset.
    logic [15:0] rd_other_d;
    logic [15:0] rd_other_q;
    logic        sel_ram_q;

    // Read mux for the non-RAM sources. It samples the state as it is before
    // this edge's updates.
    always_comb begin
        rd_other_d = 16'h0000;
        if (sel_led) begin
            rd_other_d = 16'(led_q);
        end else if (sel_tmr) begin
            rd_other_d = addr[0] ? {14'b0, run_q, exp_q} : cnt_q;
        end else if (sel_sw) begin
            rd_other_d = 16'(sync2_q);
        end
    end

    // Register the non-RAM read data and the flag that selects the RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_other_q <= 16'h0000;
            sel_ram_q  <= 1'b0;
        end else begin
            rd_other_q <= rd_other_d;
            sel_ram_q  <= sel_ram;
        end
    end

    assign din = sel_ram_q ? ram_rdata_q : rd_other_q;

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-mapped responder on the processor's data bus: the other end of the address/data-out/write protocol that the processor drives. It serves a single-port word RAM, an LED output register, a one-shot down-counting timer, and synchronized switch inputs. Every read returns registered data exactly one cycle after the address is presented, matching the processor's fetch and load timing.

## Interface
Parameters:
- RAM_AW, 8: RAM word-address width (256 × 16-bit words).
- SW_W, 10: switch input width.
- LED_W, 10: LED register width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- addr  in  16  word address from the processor's address register.
- dout  in  16  write data from the processor's data-out register.
- w  in  1  write strobe; active-high, one cycle per store.
- din  out  16  registered read data to the processor.
- sw  in  SW_W  asynchronous switch inputs.
- ledr  out  LED_W  LED register.

## Operation
- Region select is addr[15:12]. 0x0 is RAM, indexed by addr[RAM_AW-1:0] (upper bits ignored). 0x1 is LED. 0x2 is the timer. 0x3 is switches. 0x4–0xF are unmapped.
- RAM:
  - Synchronous write when w=1 and region=0x0.
  - Read-first: a read and a write to the same word in the same cycle returns the old data.
  - Contents are not reset.
- LED:
  - Write loads dout[LED_W-1:0] into ledr.
  - Read returns ledr, zero-extended.
- Timer:
  - Registers: 16-bit cnt, run flag, sticky exp flag.
  - Write to 0x2000 (addr[0]=0): cnt ← dout, run ← (dout≠0), exp unchanged. A write of 0 stops the timer.
  - While run=1: cnt decrements by 1 each cycle. On the 1→0 transition: run ← 0, exp ← 1.
  - Write to 0x2001 with dout[0]=1 clears exp. dout[0]=0 has no effect.
  - Read 0x2000 returns cnt. Read 0x2001 returns {14'b0, run, exp}.
  - addr[11:1] are ignored in the timer region.
- Switches:
  - Two-flop synchronizer (sync1, sync2).
  - Read returns sync2, zero-extended. Writes are ignored.
- Unmapped region: reads return 0x0000; writes are ignored.
- Simultaneous events:
  - Load write on the same cycle cnt reaches 0: load wins; exp is not set.
  - exp-clear write on the same cycle as expiry: set wins, exp=1.
  - w=1 only affects the addressed region; all other state is unaffected.

## Timing
- Read latency is 1 cycle. At each rising edge, din ← read-mux(addr). The value sampled is the state before that edge's updates (pre-write, pre-decrement).
- Write latency: the new value is stored at the edge where w=1. The following read returns it.
- ledr changes at the same edge as the write.
- Switch latency: a change on sw appears on din 3 edges after being sampled (sync1, sync2, din), provided addr selects switches.
- Timer: a load at edge E gives cnt=N after E. Then cnt=N−1 after E+1, and 0 after E+N. exp=1 and run=0 after E+N.
- Reset (asynchronous assert, clock-independent) clears:
  - din=0, ledr=0.
  - cnt=0, run=0, exp=0.
  - sync1=sync2=0.
- RAM is untouched by reset. Reset during a write cycle may leave that single RAM word undefined; the bench must not check it.
- Deassertion is assumed synchronous to clk at system level. The first active edge after deassertion behaves as a normal cycle.
- The processor's fetch timing relies on this latency: address presented in cycle T1, instruction taken from din in cycle T2.

## Test plan
- Reset: hold reset_n=0 mid-cycle with nonzero state present → din=0x0000, ledr=0, timer status reads 0x0000 after release.
- RAM: write 0xA5A5 to 0x0003, then 0x1234 to 0x0103 (aliases word 3) → read 0x0003 gives 0x1234 one cycle later. Read and write 0x5555 to word 3 in the same cycle → din=0x1234; next read gives 0x5555.
- LED and unmapped: write 0xFFFF to 0x1000 → ledr=0x3FF at that edge, read returns 0x03FF. Write 0xBEEF to 0x7000, then read 0x7000 → 0x0000, with ledr and RAM unchanged.
- Timer expiry: write 3 to 0x2000 → reads of 0x2000 on successive cycles give 3,2,1,0, then 0x2001 reads 0x0001. Write 1 to 0x2001 → 0x2001 reads 0x0000. Write 0 to 0x2000 → run=0, exp stays 0.
- Timer collisions:
  - Load 1, then write 5 to 0x2000 on the cycle cnt hits 0 → cnt=5, run=1, exp=0.
  - Separately, clear exp on the expiry cycle → exp=1.
- Switches: sw=0x2AA with addr=0x3000 held → din=0x02AA exactly 3 edges after the change. A one-cycle glitch on sw that misses the sampling edge → no change on din.
